// File: rtl/reg_file.sv
// rtl/reg_file.sv - MIPS register file with write-pending scoreboard (optional REGFILE_BYPASS_EN)
module reg_file #(
    parameter int PEND_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs_addr,
    output logic [31:0] rs_val,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rt_val,
    output logic        rs_busy,
    output logic        rt_busy,
    input  logic [4:0]  iss_addr,
    input  logic        iss_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_din,
    input  logic        wb_we,
    output logic        sb_err
);

    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    // Entry 0 exists only to keep indexing uniform; it is cleared on reset and never written.
    logic [31:0]       regs     [0:31];
    logic [PEND_W-1:0] pend     [0:31];
    logic [PEND_W-1:0] pend_nxt [0:31];
    logic              err_set;
    logic              inc;
    logic              dec;

    // Next pending count per register; same-cycle issue and writeback cancel out.
    always_comb begin
        err_set     = 1'b0;
        inc         = 1'b0;
        dec         = 1'b0;
        pend_nxt[0] = '0;
        for (int r = 1; r < 32; r++) begin
            inc         = iss_we && (iss_addr == 5'(r));
            dec         = wb_we && (wb_addr == 5'(r));
            pend_nxt[r] = pend[r];
            if (inc && !dec) begin
                if (pend[r] == PEND_MAX)
                    err_set = 1'b1;
                else
                    pend_nxt[r] = pend[r] + PEND_ONE;
            end else if (dec && !inc) begin
                if (pend[r] == '0)
                    err_set = 1'b1;
                else
                    pend_nxt[r] = pend[r] - PEND_ONE;
            end
        end
    end

    // Register array, pending counters and sticky error; reset discards everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                regs[r] <= '0;
                pend[r] <= '0;
            end
            sb_err <= 1'b0;
        end else begin
            if (wb_we && (wb_addr != 5'd0))
                regs[wb_addr] <= wb_din;
            for (int r = 0; r < 32; r++)
                pend[r] <= pend_nxt[r];
            if (err_set)
                sb_err <= 1'b1;
        end
    end

    // Combinational read ports and busy flags; r0 is always zero and never busy.
    always_comb begin
        rs_val  = '0;
        rt_val  = '0;
        rs_busy = 1'b0;
        rt_busy = 1'b0;
        if (rs_addr != 5'd0) begin
            rs_val  = regs[rs_addr];
            rs_busy = (pend[rs_addr] != '0);
`ifdef REGFILE_BYPASS_EN
            if (wb_we && (wb_addr == rs_addr)) begin
                rs_val  = wb_din;
                rs_busy = (pend[rs_addr] > PEND_ONE);
            end
`endif
        end
        if (rt_addr != 5'd0) begin
            rt_val  = regs[rt_addr];
            rt_busy = (pend[rt_addr] != '0);
`ifdef REGFILE_BYPASS_EN
            if (wb_we && (wb_addr == rt_addr)) begin
                rt_val  = wb_din;
                rt_busy = (pend[rt_addr] > PEND_ONE);
            end
`endif
        end
    end

endmodule

// File: doc/reg_file.md
# reg_file

General-purpose register file and write-pending scoreboard for the 5-stage MIPS core. It receives the write port driven by the writeback stage (`reg_addr`/`reg_din`/`reg_we`) and serves two combinational read ports to decode. It also tracks in-flight destination writes per register, so decode can stall on read-after-write hazards. Register 0 is hardwired to zero and is never pending.

## Interface
Parameters:
- `PEND_W`, 2: width of each per-register pending counter. Maximum writes in flight per register is 2^PEND_W-1.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `rs_addr`  in  5  read port A address (decode).
- `rs_val`  out  32  read port A data, combinational.
- `rt_addr`  in  5  read port B address (decode).
- `rt_val`  out  32  read port B data, combinational.
- `rs_busy`  out  1  register `rs_addr` has a pending write.
- `rt_busy`  out  1  register `rt_addr` has a pending write.
- `iss_addr`  in  5  destination register of the instruction leaving decode.
- `iss_we`  in  1  marks `iss_addr` as pending this cycle.
- `wb_addr`  in  5  write address from writeback (`reg_addr`).
- `wb_din`  in  32  write data from writeback (`reg_din`).
- `wb_we`  in  1  write enable from writeback (`reg_we`).
- `sb_err`  out  1  sticky scoreboard error: overflow or underflow.

## Operation
- Storage: 31 x 32-bit registers for r1..r31. r0 always reads 0.
- Write: on a clock edge with `wb_we`=1 and `wb_addr`!=0, `regs[wb_addr]`<=`wb_din`. Writes to r0 are dropped.
- Read: `rs_val` = `rs_addr`==0 ? 0 : `regs[rs_addr]`. `rt_val` is the same for port B. Both are purely combinational from the stored array, except as modified by the bypass feature (see Configuration).
- Scoreboard: each register r1..r31 has a `pend[r]` counter of width `PEND_W`.
  - inc = `iss_we` && `iss_addr`==r && r!=0.
  - dec = `wb_we` && `wb_addr`==r && r!=0.
  - inc && !dec: if `pend[r]` is at max, hold the value and set `sb_err`. Otherwise add 1.
  - dec && !inc: if `pend[r]`==0, hold at 0 and set `sb_err`. Otherwise subtract 1.
  - inc && dec: no change and no error, even when `pend[r]` is 0 or at max.
- Busy: `rs_busy` = `rs_addr`!=0 && `pend[rs_addr]`!=0. `rt_busy` is the same for port B.
- `sb_err` is sticky and is cleared only by `rst`.
- Reset clears all registers to 0, all `pend` counters to 0, and `sb_err` to 0.
  - After the reset edge, every read returns 0 and every busy output is 0.
  - `iss_we` and `wb_we` are ignored on any cycle where `rst`=1.

## Timing
- Write latency: without bypass, a value written at edge N is readable after edge N, i.e. in cycle N+1.
- Pending latency: a register issued at edge N reads busy from cycle N+1.
- Busy clears after the write edge that brings the counter to 0.
- Reads, busy outputs, and bypass are zero-cycle combinational paths from the address inputs.
- There is no handshake; `iss_we` and `wb_we` are single-cycle strobes.
- Reset asserted mid-operation discards all pending state at that edge. In-flight writebacks that arrive after reset then underflow and set `sb_err`. Pipeline flush on reset is the core's responsibility.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - A read whose address equals `wb_addr`, with `wb_we`=1 and address!=0, returns `wb_din` in the same cycle.
  - Busy for that address is computed as if the pending decrement had already happened: busy = (`pend`-1)!=0 when `pend`!=0.
- `REGFILE_BYPASS_EN` undefined:
  - Reads and busy use stored state only.
  - The writeback value and the busy clear are visible one cycle later.

## Test plan
- Reset, then read r0..r31 on both ports -> every value is 0 and every busy is 0. Issue and write r0 with 0xDEADBEEF -> r0 still reads 0, `rs_busy`=0, `sb_err`=0.
- Write r5=0x12345678 at edge N -> `rs_val`=0x12345678 in cycle N+1. In cycle N:
  - with `REGFILE_BYPASS_EN`: `rs_val`=0x12345678.
  - without it: the old value, 0.
- Issue r7 twice, then write back twice -> `rt_busy` is 1 after the first issue and stays 1 after the first write. It drops to 0 after the second write, or in the second write's own cycle with bypass.
- Issue r9 and write back r9 in the same cycle with `pend`=0 -> `pend` stays 0, `sb_err`=0. Then `wb_we` alone to r9 -> `sb_err`=1, and it stays 1 until `rst`.
- With `PEND_W`=2, issue r3 four times -> `sb_err` rises on the 4th issue. Three writebacks return `pend` to 0 and `rs_busy`=0.
- Write r10=0xA5A5A5A5 and issue r10, then assert `rst` for one cycle -> r10 reads 0 and `rs_busy`=0. A following stray writeback to r10 -> `sb_err`=1.
